// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB types and helpers for the bridge-side arbiter.
//   state_t        : HTRANS encoding (IDLE/BUSY/NONSEQ/SEQ)
//   burst_t        : HBURST encoding
//   DEFAULT_MASTER : master that owns the bus when nobody requests
//   burst_beats()  : number of address beats L in a burst (1 for SINGLE/INCR)
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } burst_t;

    localparam int DEFAULT_MASTER = 0;

    // Undefined-length INCR counts as one beat; its lock comes from HBUSREQ.
    function automatic logic [4:0] burst_beats(input burst_t b);
        logic [4:0] beats;
        case (b)
            BURST_WRAP4,  BURST_INCR4:  beats = 5'd4;
            BURST_WRAP8,  BURST_INCR8:  beats = 5'd8;
            BURST_WRAP16, BURST_INCR16: beats = 5'd16;
            default:                    beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_rr.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter
// Round-robin picker. Searches from last_grant_i+1 upward (wrapping) and
// returns the first requester as a one-hot vector. With no requester the
// default master is returned. Output is all-zero when en_i is low.
//   req_i        : request vector
//   last_grant_i : index of the most recent requester that was granted
//   en_i         : arbitration enable
//   gnt_o        : one-hot next grant
// ---------------------------------------------------------------------------
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int MW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MW-1:0]          last_grant_i,
    input  logic                   en_i,
    output logic [NUM_MASTERS-1:0] gnt_o
);

    logic [MW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        if (en_i) begin
            // k = NUM_MASTERS lands back on last_grant itself, so a lone
            // requester that already owns the bus keeps it.
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                idx = MW'((int'(last_grant_i) + k) % NUM_MASTERS);
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
            if (!found) begin
                gnt_o[DEFAULT_MASTER] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bridge_arbiter
// Shares the single AHB slave port of the AHB-to-AXI bridge between
// NUM_MASTERS masters with round-robin arbitration that never splits a burst.
//   HCLK, HRESETn      : clock, async active-low reset
//   m_HBUSREQ          : per-master request
//   m_H*               : per-master address/data phase signals, master i at
//                        bits [i*W +: W]
//   m_HGRANT, HMASTER  : registered one-hot grant, address-phase owner
//   HADDR..HBURST      : to bridge, selected by HMASTER
//   HWDATA             : to bridge, selected by the data-phase owner
//   H*_in              : from bridge; HREADY/HRDATA/HRESP broadcast back
// ---------------------------------------------------------------------------
module ahb_bridge_arbiter
    import ahb_pkg::*;
#(
    parameter  int NUM_MASTERS       = 2,
    parameter  int AHB_DATA_WIDTH    = 64,
    parameter  int AHB_ADDRESS_WIDTH = 32,
    localparam int MW                = $clog2(NUM_MASTERS)
) (
    input  logic                                      HCLK,
    input  logic                                      HRESETn,
    input  logic [NUM_MASTERS-1:0]                    m_HBUSREQ,
    input  logic [NUM_MASTERS*AHB_ADDRESS_WIDTH-1:0]  m_HADDR,
    input  logic [NUM_MASTERS*2-1:0]                  m_HTRANS,
    input  logic [NUM_MASTERS-1:0]                    m_HWRITE,
    input  logic [NUM_MASTERS*3-1:0]                  m_HSIZE,
    input  logic [NUM_MASTERS*3-1:0]                  m_HBURST,
    input  logic [NUM_MASTERS*AHB_DATA_WIDTH-1:0]     m_HWDATA,
    output logic [NUM_MASTERS-1:0]                    m_HGRANT,
    output logic [MW-1:0]                             HMASTER,
    output logic [AHB_ADDRESS_WIDTH-1:0]              HADDR,
    output logic [1:0]                                HTRANS,
    output logic                                      HWRITE,
    output logic [2:0]                                HSIZE,
    output logic [2:0]                                HBURST,
    output logic [AHB_DATA_WIDTH-1:0]                 HWDATA,
    input  logic                                      HREADY_in,
    input  logic [AHB_DATA_WIDTH-1:0]                 HRDATA_in,
    input  logic                                      HRESP_in,
    output logic                                      HREADY,
    output logic [AHB_DATA_WIDTH-1:0]                 HRDATA,
    output logic                                      HRESP
);

    localparam int AW = AHB_ADDRESS_WIDTH;
    localparam int DW = AHB_DATA_WIDTH;
    localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] grant_q, grant_d, rr_gnt;
    logic [MW-1:0]          hmaster_q, data_owner_q;
    logic [MW-1:0]          last_grant_q, last_grant_d;
    logic [MW-1:0]          grant_idx, rr_idx;
    logic [3:0]             burst_left_q, burst_left_d;
    logic                   incr_lock, handover, locked, arb_en;

    function automatic logic [MW-1:0] onehot_idx(input logic [NUM_MASTERS-1:0] oh);
        logic [MW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = MW'(i);
        end
        return idx;
    endfunction

    assign grant_idx = onehot_idx(grant_q);
    assign rr_idx    = onehot_idx(rr_gnt);

    // Address-phase mux by HMASTER, write-data mux by the data-phase owner.
    always_comb begin
        HADDR  = m_HADDR[AW-1:0];
        HTRANS = m_HTRANS[1:0];
        HWRITE = m_HWRITE[0];
        HSIZE  = m_HSIZE[2:0];
        HBURST = m_HBURST[2:0];
        HWDATA = m_HWDATA[DW-1:0];
        for (int i = 1; i < NUM_MASTERS; i++) begin
            if (hmaster_q == MW'(i)) begin
                HADDR  = m_HADDR[i*AW +: AW];
                HTRANS = m_HTRANS[i*2 +: 2];
                HWRITE = m_HWRITE[i];
                HSIZE  = m_HSIZE[i*3 +: 3];
                HBURST = m_HBURST[i*3 +: 3];
            end
            if (data_owner_q == MW'(i)) begin
                HWDATA = m_HWDATA[i*DW +: DW];
            end
        end
    end

    assign HREADY = HREADY_in;
    assign HRDATA = HRDATA_in;
    assign HRESP  = HRESP_in;

    // Remaining address beats of a fixed-length burst, advanced on acceptance.
    always_comb begin
        burst_left_d = burst_left_q;
        if (HREADY_in) begin
            case (state_t'(HTRANS))
                TR_NONSEQ: burst_left_d = 4'(burst_beats(burst_t'(HBURST)) - 5'd1);
                TR_SEQ:    if (burst_left_q != 4'd0) burst_left_d = burst_left_q - 4'd1;
                default:   ;
            endcase
        end
    end

    always_comb begin
        incr_lock = (burst_t'(HBURST) == BURST_INCR) &&
                    ((state_t'(HTRANS) == TR_SEQ) || (state_t'(HTRANS) == TR_BUSY) ||
                     ((state_t'(HTRANS) == TR_NONSEQ) && HREADY_in)) &&
                    m_HBUSREQ[hmaster_q];
        // Until the newly granted master owns the address phase, its first
        // NONSEQ is not yet visible; re-arbitrating then would steal its slot.
        handover  = (grant_idx != hmaster_q);
        locked    = (burst_left_d != 4'd0) || incr_lock || handover;
        arb_en    = HREADY_in && !locked;
    end

    ahb_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr (
        .req_i        (m_HBUSREQ),
        .last_grant_i (last_grant_q),
        .en_i         (arb_en),
        .gnt_o        (rr_gnt)
    );

    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (arb_en) begin
            grant_d = rr_gnt;
            if (|(rr_gnt & m_HBUSREQ)) last_grant_d = rr_idx;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q      <= GRANT_RST;
            hmaster_q    <= MW'(DEFAULT_MASTER);
            data_owner_q <= MW'(DEFAULT_MASTER);
            last_grant_q <= '0;
            burst_left_q <= '0;
        end else if (HREADY_in) begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_left_q <= burst_left_d;
            hmaster_q    <= grant_idx;
            data_owner_q <= hmaster_q;
        end
    end

    assign m_HGRANT = grant_q;
    assign HMASTER  = hmaster_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_bridge_arbiter
// Directed bench for ahb_bridge_arbiter with three masters: a per-cycle
// vector table for fairness, fixed-burst protection and wait states, then
// hand-written sequences for data muxing, undefined INCR and reset mid-burst.
// ---------------------------------------------------------------------------
module tb_ahb_bridge_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     req;
    logic [NM*AW-1:0]  haddr;
    logic [NM*2-1:0]   htrans;
    logic [NM-1:0]     hwrite;
    logic [NM*3-1:0]   hsize;
    logic [NM*3-1:0]   hburst;
    logic [NM*DW-1:0]  hwdata;
    logic [NM-1:0]     grant;
    logic [1:0]        hmaster;
    logic [AW-1:0]     b_haddr;
    logic [1:0]        b_htrans;
    logic              b_hwrite;
    logic [2:0]        b_hsize;
    logic [2:0]        b_hburst;
    logic [DW-1:0]     b_hwdata;
    logic              hready_in;
    logic [DW-1:0]     hrdata_in;
    logic              hresp_in;
    logic              hready;
    logic [DW-1:0]     hrdata;
    logic              hresp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ahb_bridge_arbiter #(
        .NUM_MASTERS       (NM),
        .AHB_DATA_WIDTH    (DW),
        .AHB_ADDRESS_WIDTH (AW)
    ) dut (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .m_HBUSREQ (req),
        .m_HADDR   (haddr),
        .m_HTRANS  (htrans),
        .m_HWRITE  (hwrite),
        .m_HSIZE   (hsize),
        .m_HBURST  (hburst),
        .m_HWDATA  (hwdata),
        .m_HGRANT  (grant),
        .HMASTER   (hmaster),
        .HADDR     (b_haddr),
        .HTRANS    (b_htrans),
        .HWRITE    (b_hwrite),
        .HSIZE     (b_hsize),
        .HBURST    (b_hburst),
        .HWDATA    (b_hwdata),
        .HREADY_in (hready_in),
        .HRDATA_in (hrdata_in),
        .HRESP_in  (hresp_in),
        .HREADY    (hready),
        .HRDATA    (hrdata),
        .HRESP     (hresp)
    );

    localparam logic [1:0] IDLE = 2'd0, NSEQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SGL = 3'd0, INC = 3'd1, WR4 = 3'd2, IN8 = 3'd5;

    typedef struct {
        logic [2:0] req;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       rdy;
        logic [2:0] exp_g;
        logic [1:0] exp_m;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] r, input logic [1:0] t, input logic [2:0] b,
                                input logic rd, input logic [2:0] g, input logic [1:0] m);
        vec_t v;
        v.req = r; v.trans = t; v.burst = b; v.rdy = rd; v.exp_g = g; v.exp_m = m;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [1:0] t, input logic [2:0] b);
        for (int m = 0; m < NM; m++) begin
            htrans[m*2 +: 2] = t;
            hburst[m*3 +: 3] = b;
        end
    endtask

    task automatic set_m(input int m, input logic [1:0] t, input logic [2:0] b);
        htrans[m*2 +: 2] = t;
        hburst[m*3 +: 3] = b;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        req = '0;
        hready_in = 1'b1;
        set_all(IDLE, SGL);
        tick();
        tick();
        check({tag, "_rst_grant"}, 64'(grant), 64'h1);
        check({tag, "_rst_hmaster"}, 64'(hmaster), 64'h0);
        check({tag, "_rst_hwdata"}, b_hwdata, hwdata[DW-1:0]);
        check({tag, "_rst_haddr"}, 64'(b_haddr), 64'(haddr[AW-1:0]));
        check({tag, "_rst_burst_left"}, 64'(dut.burst_left_q), 64'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        hrdata_in = 64'h0;
        hresp_in  = 1'b0;
        hwrite    = 3'b000;
        for (int m = 0; m < NM; m++) begin
            haddr[m*AW +: AW]  = 32'h0000_0100 * (m + 1);
            hwdata[m*DW +: DW] = 64'hD000_0000_0000_0000 + 64'(m);
            hsize[m*3 +: 3]    = 3'(m + 1);
        end

        // Fairness: everyone requests SINGLE transfers continuously.
        add(3'b111, NSEQ, SGL, 1, 3'b010, 2'd0);
        add(3'b111, NSEQ, SGL, 1, 3'b010, 2'd1);
        add(3'b111, NSEQ, SGL, 1, 3'b100, 2'd1);
        add(3'b111, NSEQ, SGL, 1, 3'b100, 2'd2);
        add(3'b111, NSEQ, SGL, 1, 3'b001, 2'd2);
        add(3'b111, NSEQ, SGL, 1, 3'b001, 2'd0);
        add(3'b111, NSEQ, SGL, 1, 3'b010, 2'd0);
        add(3'b111, NSEQ, SGL, 1, 3'b010, 2'd1);
        add(3'b111, NSEQ, SGL, 1, 3'b100, 2'd1);
        add(3'b111, NSEQ, SGL, 1, 3'b100, 2'd2);
        add(3'b111, NSEQ, SGL, 1, 3'b001, 2'd2);
        add(3'b111, NSEQ, SGL, 1, 3'b001, 2'd0);
        // INCR8 by master 0 with master 1 requesting and 3 wait states.
        add(3'b010, NSEQ, IN8, 1, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 1, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 0, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 1, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 1, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 0, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 1, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 1, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 0, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 1, 3'b001, 2'd0);
        add(3'b010, SEQ,  IN8, 1, 3'b010, 2'd0);
        add(3'b010, IDLE, IN8, 1, 3'b010, 2'd1);
        // Wait state holds; no requesters returns grant to master 0.
        add(3'b010, NSEQ, SGL, 0, 3'b010, 2'd1);
        add(3'b000, NSEQ, SGL, 1, 3'b001, 2'd1);
        add(3'b000, IDLE, SGL, 1, 3'b001, 2'd0);
        // Request arriving in a wait state, then a lone owner keeps the bus.
        add(3'b100, IDLE, SGL, 0, 3'b001, 2'd0);
        add(3'b100, IDLE, SGL, 1, 3'b100, 2'd0);
        add(3'b100, IDLE, SGL, 1, 3'b100, 2'd2);
        add(3'b100, IDLE, SGL, 1, 3'b100, 2'd2);

        do_reset("tbl");
        for (int i = 0; i < vecs.size(); i++) begin
            req       = vecs[i].req;
            hready_in = vecs[i].rdy;
            set_all(vecs[i].trans, vecs[i].burst);
            tick();
            check($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].exp_g));
            check($sformatf("vec%0d_hmaster", i), 64'(hmaster), 64'(vecs[i].exp_m));
        end

        // Single write from master 1 only, data routed by the data-phase owner.
        do_reset("single");
        req = 3'b010;
        tick();
        check("single_grant", 64'(grant), 64'h2);
        tick();
        check("single_hmaster", 64'(hmaster), 64'h1);
        set_m(1, NSEQ, SGL);
        hwrite[1] = 1'b1;
        haddr[1*AW +: AW] = 32'h0000_1000;
        #1;
        check("single_haddr", 64'(b_haddr), 64'h1000);
        check("single_htrans", 64'(b_htrans), 64'(NSEQ));
        check("single_hwrite", 64'(b_hwrite), 64'h1);
        check("single_hsize", 64'(b_hsize), 64'h2);
        tick();
        set_m(1, IDLE, SGL);
        hwdata[1*DW +: DW] = 64'hCAFE_F00D_1234_5678;
        #1;
        check("single_hwdata", b_hwdata, 64'hCAFE_F00D_1234_5678);
        hrdata_in = 64'h0123_4567_89AB_CDEF;
        hresp_in  = 1'b1;
        hready_in = 1'b0;
        #1;
        check("bcast_hrdata", hrdata, 64'h0123_4567_89AB_CDEF);
        check("bcast_hresp", 64'(hresp), 64'h1);
        check("bcast_hready", 64'(hready), 64'h0);
        hresp_in  = 1'b0;
        hready_in = 1'b1;
        hwrite[1] = 1'b0;

        // Undefined-length INCR: master 1 releases after its 5th beat.
        do_reset("incr");
        req = 3'b010;
        tick();
        check("incr_grant_m1", 64'(grant), 64'h2);
        req = 3'b011;
        tick();
        check("incr_hmaster_m1", 64'(hmaster), 64'h1);
        set_m(1, NSEQ, INC);
        tick();
        check("incr_beat1_grant", 64'(grant), 64'h2);
        for (int b = 2; b <= 4; b++) begin
            set_m(1, SEQ, INC);
            tick();
            check($sformatf("incr_beat%0d_grant", b), 64'(grant), 64'h2);
        end
        req = 3'b001;
        tick();
        check("incr_beat5_grant", 64'(grant), 64'h1);
        check("incr_beat5_hmaster", 64'(hmaster), 64'h1);
        set_m(1, IDLE, INC);
        tick();
        check("incr_bubble_hmaster", 64'(hmaster), 64'h0);

        // Reset asserted during beat 3 of a WRAP4 from master 0.
        do_reset("wrap");
        req = 3'b011;
        set_m(0, NSEQ, WR4);
        tick();
        check("wrap_b1_left", 64'(dut.burst_left_q), 64'h3);
        check("wrap_b1_grant", 64'(grant), 64'h1);
        set_m(0, SEQ, WR4);
        tick();
        check("wrap_b2_left", 64'(dut.burst_left_q), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("wrap_rst_left", 64'(dut.burst_left_q), 64'h0);
        check("wrap_rst_grant", 64'(grant), 64'h1);
        check("wrap_rst_hmaster", 64'(hmaster), 64'h0);
        tick();
        rst_n = 1'b1;
        set_m(0, IDLE, SGL);
        req = 3'b010;
        tick();
        check("wrap_after_grant", 64'(grant), 64'h2);
        tick();
        check("wrap_after_hmaster", 64'(hmaster), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_bridge_arbiter.md
# ahb_bridge_arbiter

Round-robin AHB arbiter and bus multiplexer that shares the single AHB slave port of the AHB-to-AXI bridge between `NUM_MASTERS` AHB masters. It grants the bus and tracks fixed-length bursts so that a burst is never split. It muxes address-phase and data-phase signals from the owning master into the bridge, and broadcasts `HREADY`, `HRDATA` and `HRESP` back to all masters. It sits directly in front of the bridge, which remains a single-master AHB slave.

## Interface
- `NUM_MASTERS`, 2 — number of requesting masters, 2..4
- `AHB_DATA_WIDTH`, 64 — data bus width
- `AHB_ADDRESS_WIDTH`, 32 — address bus width
- `MW`, `$clog2(NUM_MASTERS)` — width of the master index (local parameter)

Ports:
- `HCLK` in 1 — single clock
- `HRESETn` in 1 — asynchronous, active-low reset
- `m_HBUSREQ` in `NUM_MASTERS` — per-master bus request
- `m_HADDR` in `NUM_MASTERS` x `AHB_ADDRESS_WIDTH` — per-master address
- `m_HTRANS` in `NUM_MASTERS` x 2
- `m_HWRITE` in `NUM_MASTERS`
- `m_HSIZE` in `NUM_MASTERS` x 3
- `m_HBURST` in `NUM_MASTERS` x 3
- `m_HWDATA` in `NUM_MASTERS` x `AHB_DATA_WIDTH`
- `m_HGRANT` out `NUM_MASTERS` — one-hot grant, registered
- `HMASTER` out `MW` — address-phase owner, registered
- `HADDR`, `HTRANS`, `HWRITE`, `HSIZE`, `HBURST` out — to bridge, muxed by `HMASTER`
- `HWDATA` out `AHB_DATA_WIDTH` — to bridge, muxed by the data-phase owner
- `HREADY_in` in 1, `HRDATA_in` in `AHB_DATA_WIDTH`, `HRESP_in` in 1 — from bridge
- `HREADY`, `HRDATA`, `HRESP` out — combinational broadcast of the `_in` signals to all masters

## Operation
- Reset values: `m_HGRANT` = 1 (master 0 is the default master), `HMASTER` = 0, `data_owner` = 0, `burst_left` = 0, `last_grant` = 0. The bridge-side outputs follow master 0's inputs through the mux.
- Burst tracking follows address-phase acceptance, where accepted means `HREADY_in` = 1 at the edge.
  - NONSEQ accepted: `burst_left` is loaded with L-1, where L is 1 for SINGLE and INCR, 4 for WRAP4/INCR4, 8 for WRAP8/INCR8, and 16 for WRAP16/INCR16.
  - SEQ accepted with `burst_left` > 0: decrement `burst_left`.
  - IDLE or BUSY: `burst_left` holds.
  - `burst_left` is a 4-bit counter.
- `locked` holds when either condition is true:
  - `burst_left_next` ≠ 0, or
  - the owner is in an undefined-length INCR burst (`HBURST` = INCR, `HTRANS` is SEQ or BUSY, or NONSEQ just accepted) and the owner's `m_HBUSREQ` = 1.
- Arbitration happens only at an edge with `HREADY_in` = 1 and `locked` = 0.
  - Search order is round-robin, starting at `last_grant`+1 and wrapping modulo `NUM_MASTERS`.
  - The first requester found is granted.
  - If no master is requesting, grant goes to master 0.
  - If the only requester is the current owner, it keeps the grant.
  - `last_grant` updates whenever the grant goes to a requester.
- `HMASTER` <= granted index at every edge with `HREADY_in` = 1.
- `data_owner` <= `HMASTER` at every edge with `HREADY_in` = 1.
- A master granted without a request must drive IDLE; the arbiter passes this through and does not force IDLE itself.
- `HRESP` is passed through unchanged; there is no retry or split support.

## Timing
- Request to bus:
  - request seen at edge N (bus unlocked, `HREADY_in` = 1) → `m_HGRANT` high after N;
  - `HMASTER` switches at edge N+1 if `HREADY_in` = 1;
  - the master's NONSEQ is on `HADDR` in cycle N+1..N+2.
- Handover:
  - a fixed burst releases only after its last address beat is accepted;
  - the old owner then holds the address phase for one more cycle, driving IDLE, a one-cycle bubble;
  - the old owner's last data phase completes while `HMASTER` is already the new master.
- Wait states:
  - with `HREADY_in` = 0, `m_HGRANT`, `HMASTER`, `data_owner` and `burst_left` all hold;
  - requests arriving during wait states are arbitrated at the first ready edge.
- Simultaneous requests at reset release are served in order 1, 2, …, 0, because `last_grant` = 0.
- Reset mid-burst:
  - all state returns to reset values immediately (asynchronous);
  - the partial burst is abandoned, and the bridge's own reset clears its side.

## Structure
- `ahb_pkg` gets:
  - a `burst_beats(burst_t)` function returning L;
  - the localparam `DEFAULT_MASTER` = 0.
- `state_t` and `burst_t` are reused from `ahb_pkg`.
- Sub-module `ahb_rr_arbiter`: a parameterised round-robin picker.
  - Inputs: request vector, `last_grant`, enable.
  - Output: one-hot next grant.
- The top level holds the burst counter, the lock logic, `HMASTER`/`data_owner` and the muxes.

## Test plan
- Reset: hold `HRESETn` = 0 → `m_HGRANT` = 2'b01, `HMASTER` = 0, `HWDATA` = `m_HWDATA[0]`.
- Single writes, master 1 only: `m_HBUSREQ` = 2'b10 → `m_HGRANT` = 2'b10 one cycle later; NONSEQ to 0x1000 reaches the bridge; `HWDATA` = master 1's data in the next ready cycle.
- INCR8 protection: master 0 starts INCR8 at 0x2000 while master 1 requests → grant stays with 0 for all 8 accepted beats, including 3 inserted wait states; moves to master 1 only after the 8th address is accepted.
- Round-robin fairness, 3 masters: all request continuously with SINGLE transfers → grant sequence 1, 2, 0, 1, 2, 0.
- Undefined INCR: master 1 runs INCR and deasserts `m_HBUSREQ` after 5 beats → master 1 keeps the grant through beat 5, then the grant moves to the pending master 0.
- Reset mid-burst: assert `HRESETn` = 0 at beat 3 of a WRAP4 → `burst_left` = 0 and `m_HGRANT` = 2'b01 immediately; a new request after reset is granted normally.
